sw_phase_seq: RTL
=================

# sw_phase_seq

Switch-phase sequencer that sits directly downstream of the clock-start stage. It waits for the one-cycle switch-on pulse and the go level from that stage. It then drives a precharge phase followed by two non-overlapping switch phases separated by dead time. It stops after a programmed number of periods, or immediately on abort.

## Interface
- `CNT_W`, 8: width of the internal phase counter and of `period_cnt`.
- `PRE_CYCLES`, 4: length of the precharge phase in cycles (≥1).
- `DEAD_CYCLES`, 2: dead time before each switch phase (≥1).
- `HALF_CYCLES`, 8: length of each switch phase A/B (≥1).
- `NUM_PERIODS`, 0: number of A/B periods to run; 0 = run until stopped.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `go` in 1: run-permit level from the upstream start stage; 0 forces abort.
- `start` in 1: one-cycle switch-on pulse from the upstream stage.
- `stop` in 1: synchronous abort request, level or pulse.
- `phi_pre` out 1: precharge switch drive.
- `phi_a` out 1: phase-A switch drive.
- `phi_b` out 1: phase-B switch drive.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse on normal completion.
- `abort` out 1: one-cycle pulse on stop/go-loss termination.
- `period_cnt` out CNT_W: number of completed A/B periods since the last accepted start.

## Operation
- States: IDLE, PRE, DEAD_A, A, DEAD_B, B. The state is registered.
- Moore outputs:
  - `phi_pre` = PRE; `phi_a` = A; `phi_b` = B.
  - `busy` = not IDLE.
  - `phi_a` and `phi_b` are never high together, and neither is ever high with `phi_pre`.
- IDLE→PRE when `start`=1, `go`=1 and `stop`=0. The phase counter loads, and `period_cnt` clears to 0 in the same edge.
- PRE→DEAD_A after PRE_CYCLES cycles in PRE.
- DEAD_A→A after DEAD_CYCLES cycles.
- A→DEAD_B after HALF_CYCLES cycles.
- DEAD_B→B after DEAD_CYCLES cycles.
- End of B (HALF_CYCLES cycles):
  - `period_cnt` increments.
  - If NUM_PERIODS≠0 and the incremented value equals NUM_PERIODS: →IDLE and `done`=1 for the next cycle.
  - Otherwise →DEAD_A.
- Any non-IDLE state with `stop`=1 or `go`=0 → IDLE on the next edge, with `abort`=1 for one cycle. `period_cnt` holds its value.
- Abort has priority over every phase transition, including the final-period completion in the same cycle. Only `abort` asserts in that case, never `done`.
- `start` while `busy` is ignored; there is no restart.
- `start` with `go`=0 or `stop`=1 in IDLE is ignored.
- With NUM_PERIODS=0, `period_cnt` wraps from 2^CNT_W−1 to 0 and the sequence continues.
- Phase counter: counts down from length−1 to 0, then reloads on each state change. Parameter values must fit in CNT_W; this is enforced by elaboration check.

## Timing
- Reset: state=IDLE, counters 0. All outputs 0: `phi_pre`, `phi_a`, `phi_b`, `busy`, `done`, `abort`, `period_cnt`.
- `rst` asserted mid-sequence returns to IDLE on the next edge with all outputs 0. `abort` does not pulse on reset.
- Start latency: `start` sampled at edge N → `phi_pre`/`busy` high from cycle N+1.
- Each output phase is high for exactly its parameter length in cycles.
- Dead gaps: exactly DEAD_CYCLES cycles with all phi low.
- Period length = 2·DEAD_CYCLES + 2·HALF_CYCLES cycles.
- `done`/`abort` are high in the first IDLE cycle. `busy` is low in that same cycle.
- Abort latency: `stop`/`go` drop sampled at edge N → phi outputs low from cycle N+1.
- A new `start` is accepted in the same cycle that `done` or `abort` is high.

## Test plan
- Defaults, NUM_PERIODS=2, `start` at cycle 0 with `go`=1:
  - `phi_pre` high cycles 1–4.
  - `phi_a` high 7–14, `phi_b` high 17–24.
  - `period_cnt`=1 at cycle 25.
  - Second B ends at cycle 44.
  - Cycle 45: `done`=1, `busy`=0, `period_cnt`=2.
- Run forever (NUM_PERIODS=0), `stop` pulsed at cycle 10 (inside A):
  - `phi_a`=0 and `abort`=1 at cycle 11.
  - `done` never asserts.
  - `period_cnt` stays 0.
- `go` dropped at cycle 20 (inside B): `abort`=1 at 21 and `period_cnt` remains 0. A later `start` with `go`=1 restarts PRE and clears the count.
- `start` pulses while busy at cycles 5 and 30: sequence timing identical to the first scenario.
- `start` with `go`=0, and separately `start`+`stop` together in IDLE: outputs stay 0.
- `rst` at cycle 12 mid-A: all outputs 0 at cycle 13, no `abort` pulse. CNT_W=2 with NUM_PERIODS=0: `period_cnt` wraps 3→0 after the 4th period.

Source files
------------

// File: rtl/sw_phase_seq.sv
// Switch-phase sequencer: precharge, then non-overlapping A/B switch phases separated
// by dead time, for a programmed number of periods or until stop / loss of go.
module sw_phase_seq #(
  parameter int CNT_W       = 8,
  parameter int PRE_CYCLES  = 4,
  parameter int DEAD_CYCLES = 2,
  parameter int HALF_CYCLES = 8,
  parameter int NUM_PERIODS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             start,
  input  logic             stop,
  output logic             phi_pre,
  output logic             phi_a,
  output logic             phi_b,
  output logic             busy,
  output logic             done,
  output logic             abort,
  output logic [CNT_W-1:0] period_cnt
);

  // Phase lengths are loaded as length-1, so length-1 and the period target must fit.
  if (CNT_W < 1 || PRE_CYCLES < 1 || DEAD_CYCLES < 1 || HALF_CYCLES < 1 ||
      NUM_PERIODS < 0 || PRE_CYCLES > (1 << CNT_W) || DEAD_CYCLES > (1 << CNT_W) ||
      HALF_CYCLES > (1 << CNT_W) || NUM_PERIODS >= (1 << CNT_W)) begin : g_bad_params
    $error("sw_phase_seq: parameter out of range for CNT_W");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRE    = 3'd1,
    S_DEAD_A = 3'd2,
    S_A      = 3'd3,
    S_DEAD_B = 3'd4,
    S_B      = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] PRE_LOAD  = CNT_W'(PRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_CYCLES - 1);
  localparam logic [CNT_W-1:0] NUM_P     = CNT_W'(NUM_PERIODS);

  state_e           state_r;
  state_e           nxt_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] nxt_cnt_s;
  logic [CNT_W-1:0] nxt_period_s;
  logic [CNT_W-1:0] period_inc_s;
  logic             cnt_zero_s;
  logic             done_s;
  logic             abort_s;

  assign cnt_zero_s   = (cnt_r == {CNT_W{1'b0}});
  assign period_inc_s = period_cnt + CNT_W'(1);

  // Next-state, phase counter and period count; abort outranks every phase transition.
  always_comb begin
    nxt_state_s  = state_r;
    nxt_cnt_s    = cnt_r;
    nxt_period_s = period_cnt;
    done_s       = 1'b0;
    abort_s      = 1'b0;
    if (state_r != S_IDLE && (stop || !go)) begin
      nxt_state_s = S_IDLE;
      nxt_cnt_s   = {CNT_W{1'b0}};
      abort_s     = 1'b1;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start && go && !stop) begin
            nxt_state_s  = S_PRE;
            nxt_cnt_s    = PRE_LOAD;
            nxt_period_s = {CNT_W{1'b0}};
          end else begin
            nxt_cnt_s = {CNT_W{1'b0}};
          end
        end
        S_PRE: begin
          if (cnt_zero_s) begin
            nxt_state_s = S_DEAD_A;
            nxt_cnt_s   = DEAD_LOAD;
          end else begin
            nxt_cnt_s = cnt_r - CNT_W'(1);
          end
        end
        S_DEAD_A: begin
          if (cnt_zero_s) begin
            nxt_state_s = S_A;
            nxt_cnt_s   = HALF_LOAD;
          end else begin
            nxt_cnt_s = cnt_r - CNT_W'(1);
          end
        end
        S_A: begin
          if (cnt_zero_s) begin
            nxt_state_s = S_DEAD_B;
            nxt_cnt_s   = DEAD_LOAD;
          end else begin
            nxt_cnt_s = cnt_r - CNT_W'(1);
          end
        end
        S_DEAD_B: begin
          if (cnt_zero_s) begin
            nxt_state_s = S_B;
            nxt_cnt_s   = HALF_LOAD;
          end else begin
            nxt_cnt_s = cnt_r - CNT_W'(1);
          end
        end
        S_B: begin
          if (cnt_zero_s) begin
            nxt_period_s = period_inc_s;
            if (NUM_PERIODS != 0 && period_inc_s == NUM_P) begin
              nxt_state_s = S_IDLE;
              nxt_cnt_s   = {CNT_W{1'b0}};
              done_s      = 1'b1;
            end else begin
              nxt_state_s = S_DEAD_A;
              nxt_cnt_s   = DEAD_LOAD;
            end
          end else begin
            nxt_cnt_s = cnt_r - CNT_W'(1);
          end
        end
        default: begin
          nxt_state_s = S_IDLE;
          nxt_cnt_s   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State, counters and Moore outputs, all registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      period_cnt <= {CNT_W{1'b0}};
      phi_pre    <= 1'b0;
      phi_a      <= 1'b0;
      phi_b      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      abort      <= 1'b0;
    end else begin
      state_r    <= nxt_state_s;
      cnt_r      <= nxt_cnt_s;
      period_cnt <= nxt_period_s;
      phi_pre    <= (nxt_state_s == S_PRE);
      phi_a      <= (nxt_state_s == S_A);
      phi_b      <= (nxt_state_s == S_B);
      busy       <= (nxt_state_s != S_IDLE);
      done       <= done_s;
      abort      <= abort_s;
    end
  end

endmodule
